bcd_counter_2d: RTL and testbench

- Two-digit synchronous BCD up/down counter with parallel load and load validation.
- Sits directly upstream of the BCD-to-binary converter and drives its 8-bit BCD input ({tens, ones}).
- Count range is 00..MAX_BCD. The default of 15 matches the converter's input range 00..15.
- Emits a terminal-count strobe for cascading and a sticky error flag when a load is rejected.

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_counter_2d_if.sv | 30 +++
 rtl/bcd_digit.sv | 55 +++++
 rtl/bcd_counter_2d.sv | 90 +++++++++
 tb/tb_bcd_counter_2d.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_pkg
//  Purpose  : Shared constants and helpers for the packed two-digit BCD counter.
//  Revision : 1.0
// ============================================================================
package bcd_pkg;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
    localparam int         BCD2_W        = 8;

    function automatic logic bcd_digit_valid(input logic [3:0] digit);
        return (digit <= BCD_DIGIT_MAX);
    endfunction

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_counter_2d_if.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_counter_2d_if
//  Purpose  : Control/status bundle between the BCD counter and its controller.
//  Revision : 1.0
// ============================================================================
interface bcd_counter_2d_if;
    import bcd_pkg::*;

    logic              en;
    logic              up;
    logic              load;
    logic [BCD2_W-1:0] load_val;
    logic              clr_err;
    logic [BCD2_W-1:0] bcd;
    logic              tc;
    logic              err;

    modport master (
        output en, up, load, load_val, clr_err,
        input  bcd, tc, err
    );

    modport slave (
        input  en, up, load, load_val, clr_err,
        output bcd, tc, err
    );

endinterface : bcd_counter_2d_if
`default_nettype wire

// File: rtl/bcd_digit.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_digit
//  Purpose  : One registered BCD digit with up/down stepping, whole-counter wrap,
//             parallel load and carry/borrow out to the next digit.
//  Revision : 1.0
// ============================================================================
module bcd_digit
    import bcd_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       step,
    input  wire logic       up,
    input  wire logic       wrap,
    input  wire logic [3:0] wrap_hi,
    input  wire logic [3:0] wrap_lo,
    input  wire logic       load,
    input  wire logic [3:0] load_digit,
    output logic      [3:0] digit,
    output logic            carry
);

    logic [3:0] r_digit;
    logic [3:0] w_next;

    // wrap_lo is the digit value after an upward wrap, wrap_hi after a downward one
    always_comb begin
        w_next = r_digit;
        if (load) begin
            w_next = load_digit;
        end else if (wrap) begin
            w_next = up ? wrap_lo : wrap_hi;
        end else if (step) begin
            if (up) begin
                w_next = (r_digit == BCD_DIGIT_MAX) ? 4'd0 : r_digit + 4'd1;
            end else begin
                w_next = (r_digit == 4'd0) ? BCD_DIGIT_MAX : r_digit - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_digit <= 4'd0;
        end else begin
            r_digit <= w_next;
        end
    end

    assign digit = r_digit;
    assign carry = step & ~wrap & (up ? (r_digit == BCD_DIGIT_MAX) : (r_digit == 4'd0));

endmodule : bcd_digit
`default_nettype wire

// File: rtl/bcd_counter_2d.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_counter_2d
//  Purpose  : Two-digit BCD up/down counter, range 00..MAX_BCD, with validated
//             parallel load, terminal-count strobe and sticky load-error flag.
//  Revision : 1.0
// ============================================================================
module bcd_counter_2d
    import bcd_pkg::*;
#(
    parameter logic [BCD2_W-1:0] MAX_BCD = 8'h15
)
(
    input  wire logic          clk,
    input  wire logic          rst_n,
    bcd_counter_2d_if.slave    bus
);

    logic [BCD2_W-1:0] w_bcd;
    logic              w_step;
    logic              w_at_max;
    logic              w_at_zero;
    logic              w_wrap;
    logic              w_load_valid;
    logic              w_load_ok;
    logic              w_load_bad;
    logic              w_ones_carry;
    logic              w_tens_carry;
    logic              r_err;

    assign w_step    = bus.en & ~bus.load;
    assign w_at_max  = (w_bcd == MAX_BCD);
    assign w_at_zero = (w_bcd == '0);
    assign w_wrap    = w_step & (bus.up ? w_at_max : w_at_zero);

    // Packed BCD with valid nibbles preserves numeric order, so a plain compare works
    assign w_load_valid = bcd_digit_valid(bus.load_val[7:4])
                        & bcd_digit_valid(bus.load_val[3:0])
                        & (bus.load_val <= MAX_BCD);
    assign w_load_ok    = bus.load & w_load_valid;
    assign w_load_bad   = bus.load & ~w_load_valid;

    bcd_digit u_ones (
        .clk        (clk),
        .rst_n      (rst_n),
        .step       (w_step),
        .up         (bus.up),
        .wrap       (w_wrap),
        .wrap_hi    (MAX_BCD[3:0]),
        .wrap_lo    (4'd0),
        .load       (w_load_ok),
        .load_digit (bus.load_val[3:0]),
        .digit      (w_bcd[3:0]),
        .carry      (w_ones_carry)
    );

    bcd_digit u_tens (
        .clk        (clk),
        .rst_n      (rst_n),
        .step       (w_ones_carry),
        .up         (bus.up),
        .wrap       (w_wrap),
        .wrap_hi    (MAX_BCD[7:4]),
        .wrap_lo    (4'd0),
        .load       (w_load_ok),
        .load_digit (bus.load_val[7:4]),
        .digit      (w_bcd[7:4]),
        .carry      (w_tens_carry)
    );

    // A rejected load takes precedence over a same-cycle clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_load_bad) begin
            r_err <= 1'b1;
        end else if (bus.clr_err) begin
            r_err <= 1'b0;
        end
    end

    assign bus.bcd = w_bcd;
    assign bus.tc  = rst_n & w_wrap;
    assign bus.err = r_err;

    logic w_unused;
    assign w_unused = w_tens_carry;

endmodule : bcd_counter_2d
`default_nettype wire

// File: tb/tb_bcd_counter_2d.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_counter_2d
//  Purpose  : Self-checking bench for bcd_counter_2d at MAX_BCD = 15 and 23.
//  Revision : 1.0
// ============================================================================
module tb_bcd_counter_2d;

    typedef struct {
        int         d;
        string      tag;
        logic       tc;
        logic [7:0] bcd;
        logic       err;
    } exp_t;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   n_total;
    int   n_pass;
    exp_t sb[$];

    logic [7:0] m_bcd [2];
    logic       m_err [2];
    logic [7:0] c_max [2];

    bcd_counter_2d_if ifa ();
    bcd_counter_2d_if ifb ();

    bcd_counter_2d #(.MAX_BCD(8'h15)) dut_a (.clk(clk), .rst_n(rst_a), .bus(ifa));
    bcd_counter_2d #(.MAX_BCD(8'h23)) dut_b (.clk(clk), .rst_n(rst_b), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int b2i(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] i2b(input int v);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    // Reference behaviour in decimal arithmetic; returns expected tc for this cycle
    function automatic logic model_step(input int d, input logic rn, input logic en,
                                        input logic up, input logic ld,
                                        input logic [7:0] lv, input logic clr);
        logic tc;
        logic ok;
        int   mx;
        tc = 1'b0;
        mx = b2i(c_max[d]);
        if (!rn) begin
            m_bcd[d] = 8'h00;
            m_err[d] = 1'b0;
        end else if (ld) begin
            ok = (lv[7:4] <= 4'd9) && (lv[3:0] <= 4'd9) && (b2i(lv) <= mx);
            if (ok) begin
                m_bcd[d] = lv;
                if (clr) m_err[d] = 1'b0;
            end else begin
                m_err[d] = 1'b1;
            end
        end else begin
            if (clr) m_err[d] = 1'b0;
            if (en) begin
                if (up) begin
                    tc       = (b2i(m_bcd[d]) == mx);
                    m_bcd[d] = i2b((b2i(m_bcd[d]) + 1) % (mx + 1));
                end else begin
                    tc       = (b2i(m_bcd[d]) == 0);
                    m_bcd[d] = tc ? c_max[d] : i2b(b2i(m_bcd[d]) - 1);
                end
            end
        end
        return tc;
    endfunction

    task automatic cyc(input int d, input string tag, input logic rn, input logic en,
                       input logic up, input logic ld, input logic [7:0] lv, input logic clr);
        exp_t e;
        exp_t g;
        logic obs_tc;
        @(negedge clk);
        if (d == 0) begin
            rst_a = rn; ifa.en = en; ifa.up = up; ifa.load = ld; ifa.load_val = lv; ifa.clr_err = clr;
            rst_b = 1'b1; ifb.en = 1'b0; ifb.load = 1'b0; ifb.clr_err = 1'b0;
        end else begin
            rst_b = rn; ifb.en = en; ifb.up = up; ifb.load = ld; ifb.load_val = lv; ifb.clr_err = clr;
            rst_a = 1'b1; ifa.en = 1'b0; ifa.load = 1'b0; ifa.clr_err = 1'b0;
        end
        e.d   = d;
        e.tag = tag;
        e.tc  = model_step(d, rn, en, up, ld, lv, clr);
        e.bcd = m_bcd[d];
        e.err = m_err[d];
        sb.push_back(e);
        #1;
        obs_tc = (d == 0) ? ifa.tc : ifb.tc;
        @(posedge clk);
        #1;
        g = sb.pop_front();
        check({g.tag, ".tc"}, {7'd0, obs_tc}, {7'd0, g.tc});
        check({g.tag, ".bcd"}, (g.d == 0) ? ifa.bcd : ifb.bcd, g.bcd);
        check({g.tag, ".err"}, {7'd0, (g.d == 0) ? ifa.err : ifb.err}, {7'd0, g.err});
    endtask

    initial begin
        logic [7:0] lv;
        n_total = 0;
        n_pass  = 0;
        c_max[0] = 8'h15;
        c_max[1] = 8'h23;
        m_bcd[0] = 8'h00; m_bcd[1] = 8'h00;
        m_err[0] = 1'b0;  m_err[1] = 1'b0;
        rst_a = 1'b0; rst_b = 1'b0;
        ifa.en = 1'b0; ifa.up = 1'b0; ifa.load = 1'b0; ifa.load_val = 8'h00; ifa.clr_err = 1'b0;
        ifb.en = 1'b0; ifb.up = 1'b0; ifb.load = 1'b0; ifb.load_val = 8'h00; ifb.clr_err = 1'b0;

        // Reset and full up-count with wrap
        cyc(0, "rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(0, "rst", 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) cyc(0, "up", 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);

        // Down-count through 00 to MAX
        cyc(0, "ld10", 1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 1'b0);
        for (int i = 0; i < 12; i++) cyc(0, "dn", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);

        // Load validation and error flag
        cyc(0, "ld1A", 1'b1, 1'b1, 1'b1, 1'b1, 8'h1A, 1'b0);
        cyc(0, "ld16", 1'b1, 1'b0, 1'b1, 1'b1, 8'h16, 1'b0);
        cyc(0, "ldA0", 1'b1, 1'b0, 1'b1, 1'b1, 8'hA0, 1'b1);
        cyc(0, "ld07clr", 1'b1, 1'b0, 1'b1, 1'b1, 8'h07, 1'b1);
        cyc(0, "ld0F", 1'b1, 1'b0, 1'b1, 1'b1, 8'h0F, 1'b0);
        cyc(0, "clr", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1);

        // Priority: load over en at MAX, then reset over load
        cyc(0, "ld15", 1'b1, 1'b0, 1'b1, 1'b1, 8'h15, 1'b0);
        cyc(0, "ldprio", 1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0);
        cyc(0, "rstprio", 1'b0, 1'b1, 1'b1, 1'b1, 8'h12, 1'b0);

        // Direction flip and hold
        cyc(0, "ld09", 1'b1, 1'b0, 1'b1, 1'b1, 8'h09, 1'b0);
        for (int i = 0; i < 4; i++) cyc(0, "flip", 1'b1, 1'b1, ((i % 2) == 0), 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) cyc(0, "hold", 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        // MAX_BCD = 23 variant
        cyc(1, "b.rst", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1, "b.ld19", 1'b1, 1'b0, 1'b1, 1'b1, 8'h19, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1, "b.up", 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1, "b.dn", 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1, "b.ld24", 1'b1, 1'b0, 1'b0, 1'b1, 8'h24, 1'b0);
        cyc(1, "b.ld23", 1'b1, 1'b0, 1'b0, 1'b1, 8'h23, 1'b0);

        // Mixed random traffic on both instances
        for (int i = 0; i < 120; i++) begin
            lv = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255))
                                             : i2b($urandom_range(0, 25));
            cyc(i % 2, "rnd", ($urandom_range(0, 19) != 0), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), lv,
                ($urandom_range(0, 7) == 0));
        end

        if (sb.size() != 0) check("sb.empty", 8'(sb.size()), 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_bcd_counter_2d
`default_nettype wire
